// File: rtl/jpeg_rle_encoder.sv
// Zigzag scanner and (run, level) run-length encoder for one 8x8 quantized block.
// Define RLE_DC_DIFF_EN to emit the DC level as a difference from the previous block's DC.
`timescale 1ns/1ps
module jpeg_rle_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] in_row,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  out_run,
    output logic [9:0]  out_level,
    output logic        out_eob,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned CW = 9;
    localparam int unsigned LW = 10;
    localparam int unsigned NCOL = 8;

    typedef enum logic [1:0] {S_LOAD, S_SCAN, S_DONE} state_t;

    // Zigzag position k -> raster index (row*8 + col)
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [CW-1:0] r_buf [64];
    state_t        r_state, w_state_n;
    logic [2:0]    r_row, w_row_n;
    logic [5:0]    r_k, w_k_n;
    logic [5:0]    r_z, w_z_n;
    logic          r_in_ready, w_in_ready_n;
    logic [3:0]    r_out_run, w_run_n;
    logic [LW-1:0] r_out_level, w_level_n;
    logic          r_out_eob, w_eob_n;
    logic          r_out_last, w_last_n;
    logic          r_out_valid, w_valid_n;
    logic          w_free;
    logic [CW-1:0] w_coef;
    logic [LW-1:0] w_dc_level;

`ifdef RLE_DC_DIFF_EN
    logic [CW-1:0] r_dc_pred;
    logic          r_out_is_dc, w_is_dc_n;

    assign w_dc_level = LW'({r_buf[0][CW-1], r_buf[0]}) - LW'({r_dc_pred[CW-1], r_dc_pred});
`else
    assign w_dc_level = {r_buf[0][CW-1], r_buf[0]};
`endif

    assign in_ready  = r_in_ready;
    assign out_run   = r_out_run;
    assign out_level = r_out_level;
    assign out_eob   = r_out_eob;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

    assign w_free = !r_out_valid || out_ready;
    assign w_coef = r_buf[ZZ_ROM[r_k]];

    // Block buffer: whole row written per accepted beat, no reset needed
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid) begin
            for (int c = 0; c < NCOL; c++) begin
                r_buf[{r_row, 3'(c)}] <= in_row[71 - 9*c -: 9];
            end
        end
    end

    // Next-state, scan step and output-register load
    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_k_n     = r_k;
        w_z_n     = r_z;
        w_run_n   = r_out_run;
        w_level_n = r_out_level;
        w_eob_n   = r_out_eob;
        w_last_n  = r_out_last;
        w_valid_n = r_out_valid && !out_ready;
`ifdef RLE_DC_DIFF_EN
        w_is_dc_n = r_out_is_dc;
`endif
        case (r_state)
            S_LOAD: begin
                if (in_valid) begin
                    w_row_n = 3'(r_row + 3'd1);
                    if (r_row == 3'd7) begin
                        w_k_n     = 6'd0;
                        w_z_n     = 6'd0;
                        w_state_n = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_free) begin
                    if (r_k == 6'd0) begin
                        w_valid_n = 1'b1;
                        w_run_n   = 4'd0;
                        w_level_n = w_dc_level;
                        w_eob_n   = 1'b0;
                        w_last_n  = 1'b0;
                        w_k_n     = 6'd1;
`ifdef RLE_DC_DIFF_EN
                        w_is_dc_n = 1'b1;
`endif
                    end else if (w_coef == '0) begin
                        w_z_n = 6'(r_z + 6'd1);
                        w_k_n = 6'(r_k + 6'd1);
                        // Trailing zeros at the final position collapse straight into EOB
                        if (r_k == 6'd63) begin
                            w_valid_n = 1'b1;
                            w_run_n   = 4'd0;
                            w_level_n = '0;
                            w_eob_n   = 1'b1;
                            w_last_n  = 1'b1;
                            w_z_n     = 6'd0;
                            w_state_n = S_DONE;
`ifdef RLE_DC_DIFF_EN
                            w_is_dc_n = 1'b0;
`endif
                        end
                    end else if (r_z >= 6'd16) begin
                        w_valid_n = 1'b1;
                        w_run_n   = 4'd15;
                        w_level_n = '0;
                        w_eob_n   = 1'b0;
                        w_last_n  = 1'b0;
                        w_z_n     = 6'(r_z - 6'd16);
`ifdef RLE_DC_DIFF_EN
                        w_is_dc_n = 1'b0;
`endif
                    end else begin
                        w_valid_n = 1'b1;
                        w_run_n   = r_z[3:0];
                        w_level_n = {w_coef[CW-1], w_coef};
                        w_eob_n   = 1'b0;
                        w_last_n  = (r_k == 6'd63);
                        w_z_n     = 6'd0;
                        w_k_n     = 6'(r_k + 6'd1);
                        if (r_k == 6'd63) begin
                            w_state_n = S_DONE;
                        end
`ifdef RLE_DC_DIFF_EN
                        w_is_dc_n = 1'b0;
`endif
                    end
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready && r_out_last) begin
                    w_state_n = S_LOAD;
                    w_row_n   = 3'd0;
                end
            end
            default: w_state_n = S_LOAD;
        endcase
        w_in_ready_n = (w_state_n == S_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_row       <= '0;
            r_k         <= '0;
            r_z         <= '0;
            r_in_ready  <= 1'b1;
            r_out_run   <= '0;
            r_out_level <= '0;
            r_out_eob   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_row       <= w_row_n;
            r_k         <= w_k_n;
            r_z         <= w_z_n;
            r_in_ready  <= w_in_ready_n;
            r_out_run   <= w_run_n;
            r_out_level <= w_level_n;
            r_out_eob   <= w_eob_n;
            r_out_last  <= w_last_n;
            r_out_valid <= w_valid_n;
        end
    end

`ifdef RLE_DC_DIFF_EN
    // Predictor follows the raw DC once its symbol has been taken downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dc_pred   <= '0;
            r_out_is_dc <= 1'b0;
        end else begin
            r_out_is_dc <= w_is_dc_n;
            if (r_out_valid && out_ready && r_out_is_dc) begin
                r_dc_pred <= r_buf[0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Directed bench for jpeg_rle_encoder with a symbol scoreboard built from a reference RLE model.
`timescale 1ns/1ps
module tb_jpeg_rle_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] in_row;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_run;
    logic [9:0]  out_level;
    logic        out_eob;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [3:0] run;
        logic [9:0] level;
        logic       eob;
        logic       last;
    } sym_t;

    sym_t              exp_q[$];
    int                n_checks = 0;
    int                n_fails  = 0;
    int                zz [64];
    logic signed [8:0] blk [64];
    logic signed [8:0] pred_m;
    int                model_zrl;
    logic [9:0]        first_level;

    always #5 clk = ~clk;

    jpeg_rle_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_run   (out_run),
        .out_level (out_level),
        .out_eob   (out_eob),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Zigzag order by walking the anti-diagonals
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r*8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r*8 + (s - r); k++; end
            end
        end
    endtask

    task automatic model_block();
        logic [9:0] dcl;
        int   z = 0;
        sym_t t;
`ifdef RLE_DC_DIFF_EN
        dcl    = {blk[0][8], blk[0]} - {pred_m[8], pred_m};
        pred_m = blk[0];
`else
        dcl = {blk[0][8], blk[0]};
`endif
        model_zrl = 0;
        exp_q.push_back('{run: 4'd0, level: dcl, eob: 1'b0, last: 1'b0});
        for (int k = 1; k < 64; k++) begin
            logic signed [8:0] v = blk[zz[k]];
            if (v == 0) begin
                z++;
            end else begin
                while (z >= 16) begin
                    exp_q.push_back('{run: 4'd15, level: 10'd0, eob: 1'b0, last: 1'b0});
                    model_zrl++;
                    z -= 16;
                end
                exp_q.push_back('{run: 4'(z), level: {v[8], v}, eob: 1'b0, last: 1'b0});
                z = 0;
            end
        end
        if (z > 0) begin
            exp_q.push_back('{run: 4'd0, level: 10'd0, eob: 1'b1, last: 1'b1});
        end else begin
            t = exp_q.pop_back();
            t.last = 1'b1;
            exp_q.push_back(t);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        pred_m = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_run"},   32'(out_run),   32'd0);
        check({tag, "_level"}, 32'(out_level), 32'd0);
        check({tag, "_eob"},   32'(out_eob),   32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic send_rows(input int nrows);
        for (int r = 0; r < nrows; r++) begin
            @(negedge clk);
            for (int c = 0; c < 8; c++) in_row[71 - 9*c -: 9] = blk[r*8 + c];
            in_valid = 1'b1;
        end
    endtask

    // Drain one block; random_ready toggles out_ready and checks stall stability
    task automatic collect(input bit random_ready);
        sym_t saved = '0;
        sym_t got;
        sym_t e;
        bit   stalled = 1'b0;
        bit   done = 1'b0;
        int   first = -1;
        int   lastc = 0;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clk);
            got = '{run: out_run, level: out_level, eob: out_eob, last: out_last};
            if (cyc == 0) begin
                check("in_ready_scan", 32'(in_ready), 32'd0);
                check("dc_not_early", 32'(out_valid), 32'd0);
                in_row   = {8{9'h0AB}};
                in_valid = 1'b1;
            end
            if (stalled && out_valid) check("stall_hold", 32'(got), 32'(saved));
            out_ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && first < 0) begin
                first = cyc;
                first_level = out_level;
            end
            if (out_valid && out_ready) begin
                check("sym_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sym", 32'(got), 32'(e));
                end
                if (out_last) begin
                    done     = 1'b1;
                    lastc    = cyc;
                    in_valid = 1'b0;
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                saved   = got;
            end else begin
                stalled = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("block_done", 32'(done), 32'd1);
        check("dc_latency", 32'(first), 32'd1);
        if (!random_ready) check("scan_bound", 32'((lastc - first) <= 64 + model_zrl), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_block(input bit random_ready);
        model_block();
        send_rows(8);
        collect(random_ready);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    initial begin
        reset = 1'b1;
        build_zz();
        do_reset();
        check_reset_outputs("rst0");

        // Partial block then reset: stale rows must not leak
        for (int i = 0; i < 64; i++) blk[i] = 9'sd77;
        send_rows(3);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        pred_m = '0;
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0) blk[i] = 9'($urandom_range(1, 255)) * (($urandom_range(0, 1) != 0) ? -9'sd1 : 9'sd1);
            else blk[i] = '0;
        end
        blk[0] = -9'sd256;
        run_block(1'b0);

        // DC only
        clear_blk();
        blk[0] = 9'sd12;
        run_block(1'b0);

        // Sparse AC with one ZRL
        clear_blk();
        blk[zz[5]]  = -9'sd3;
        blk[zz[30]] = 9'sd1;
        run_block(1'b0);

        // Exactly 16 zeros then a nonzero
        clear_blk();
        blk[0] = 9'sd5;
        blk[zz[17]] = 9'sd5;
        run_block(1'b0);

        // Only the final coefficient nonzero after 62 zeros
        clear_blk();
        blk[zz[63]] = -9'sd7;
        run_block(1'b0);

        // All ones, free-running and then with stalls
        for (int i = 0; i < 64; i++) blk[i] = 9'sd1;
        run_block(1'b0);
        run_block(1'b1);
        run_block(1'b1);

        // DC sequence from a clean predictor
        do_reset();
        clear_blk();
        blk[0] = 9'sd100;
        run_block(1'b0);
        check("dc_seq0", 32'(first_level), 32'(10'd100));
        blk[0] = 9'sd40;
        run_block(1'b0);
`ifdef RLE_DC_DIFF_EN
        check("dc_seq1", 32'(first_level), 32'(10'h3C4));
`else
        check("dc_seq1", 32'(first_level), 32'(10'd40));
`endif
        blk[0] = -9'sd50;
        run_block(1'b1);
`ifdef RLE_DC_DIFF_EN
        check("dc_seq2", 32'(first_level), 32'(10'h3A6));
`else
        check("dc_seq2", 32'(first_level), 32'(10'h3CE));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
